button_reader: RTL

Input-side counterpart to the LED output drivers. It samples the on-board active-low push-buttons and synchronises each one into the 27 MHz clock domain. It debounces each button and classifies the activity into single-cycle event pulses: press, release, long-press and auto-repeat. Downstream LED pattern blocks consume these pulses, for example to change scan speed or direction.

---
 rtl/button_reader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/button_reader.sv
// Debounces active-low push-buttons and turns their activity into single-cycle
// press, release, long-press and auto-repeat pulses, one independent FSM per channel.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | released and stable, waiting for a press
//   PRESS_DB   | raw press seen, counting stable-low cycles
//   HELD       | press accepted, timing towards long-press
//   REPEAT     | long-press reached, emitting periodic repeat pulses
//   RELEASE_DB | raw release seen while held, counting stable-high cycles
module button_reader #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int LONG_CYCLES     = 27000000,
  parameter int REPEAT_CYCLES   = 6750000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse,
  output logic [NUM_BTN-1:0] repeat_pulse
);

  localparam int MAX_DL  = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int MAX_CYC = (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);

  generate
    if (NUM_BTN < 1 || DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
      $error("button_reader: all parameters must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    RELEASE_DB = 3'd4
  } state_t;

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;

  // Preset to released so a reset never looks like an edge on the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic          pressed;
    logic          lvl;
    logic          p_press;
    logic          p_release;
    logic          p_long;
    logic          p_repeat;

    assign pressed = ~sync2[i];

    always_ff @(posedge clk) begin
      if (rst) begin
        state     <= IDLE;
        cnt       <= '0;
        lvl       <= 1'b0;
        p_press   <= 1'b0;
        p_release <= 1'b0;
        p_long    <= 1'b0;
        p_repeat  <= 1'b0;
      end else begin
        p_press   <= 1'b0;
        p_release <= 1'b0;
        p_long    <= 1'b0;
        p_repeat  <= 1'b0;
        case (state)
          IDLE: begin
            if (pressed) begin
              state <= PRESS_DB;
              cnt   <= '0;
            end
          end
          PRESS_DB: begin
            if (!pressed) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == DB_LAST) begin
              state   <= HELD;
              cnt     <= '0;
              lvl     <= 1'b1;
              p_press <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          HELD: begin
            if (!pressed) begin
              state <= RELEASE_DB;
              cnt   <= '0;
            end else if (cnt == LONG_LAST) begin
              state  <= REPEAT;
              cnt    <= '0;
              p_long <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          REPEAT: begin
            if (!pressed) begin
              state <= RELEASE_DB;
              cnt   <= '0;
            end else if (cnt == REP_LAST) begin
              cnt      <= '0;
              p_repeat <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          RELEASE_DB: begin
            // Bouncing back to pressed restarts the long-press timer from zero.
            if (pressed) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt == DB_LAST) begin
              state     <= IDLE;
              cnt       <= '0;
              lvl       <= 1'b0;
              p_release <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign btn_level[i]     = lvl;
    assign press_pulse[i]   = p_press;
    assign release_pulse[i] = p_release;
    assign long_pulse[i]    = p_long;
    assign repeat_pulse[i]  = p_repeat;
  end

endmodule
